// File: rtl/score_keeper.sv
// ============================================================================
// Module   : score_keeper
// Purpose  : Two-player BCD score tracker with IDLE/PLAY/WIN game FSM.
//            Rising edges of hit/wall inputs add points while in PLAY;
//            scores saturate at WIN_SCORE and the first (or simultaneous)
//            player to reach it wins.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module score_keeper #(
    parameter int WIN_SCORE = 21,
    parameter int HIT_PTS   = 1,
    parameter int WALL_PTS  = 2
) (
    input  logic       clkdiv0,
    input  logic       RST,
    input  logic       start,
    input  logic       hit1,
    input  logic       wall1,
    input  logic       hit2,
    input  logic       wall2,
    output logic [3:0] p1_units,
    output logic [3:0] p1_tens,
    output logic [3:0] p2_units,
    output logic [3:0] p2_tens,
    output logic [1:0] state,
    output logic [1:0] winner,
    output logic       game_over
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_PLAY = 2'b01,
        S_WIN  = 2'b10
    } state_t;

    localparam logic [6:0] c_WIN  = 7'(WIN_SCORE);
    localparam logic [7:0] c_HIT  = 8'(HIT_PTS);
    localparam logic [7:0] c_WALL = 8'(WALL_PTS);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [6:0] r_p1;
    logic [6:0] r_p2;
    logic [6:0] w_p1_nxt;
    logic [6:0] w_p2_nxt;
    logic [1:0] r_winner;
    logic [1:0] w_winner_nxt;

    logic       r_start_q;
    logic       r_hit1_q;
    logic       r_wall1_q;
    logic       r_hit2_q;
    logic       r_wall2_q;

    logic       w_start_ev;
    logic       w_hit1_ev;
    logic       w_wall1_ev;
    logic       w_hit2_ev;
    logic       w_wall2_ev;

    logic [7:0] w_inc1;
    logic [7:0] w_inc2;
    logic [7:0] w_sum1;
    logic [7:0] w_sum2;
    logic       w_reach1;
    logic       w_reach2;
    logic [6:0] w_sat1;
    logic [6:0] w_sat2;

    // Previous-value registers for edge detection, updated in every state
    always_ff @(posedge clkdiv0 or posedge RST) begin
        if (RST) begin
            r_start_q <= 1'b0;
            r_hit1_q  <= 1'b0;
            r_wall1_q <= 1'b0;
            r_hit2_q  <= 1'b0;
            r_wall2_q <= 1'b0;
        end else begin
            r_start_q <= start;
            r_hit1_q  <= hit1;
            r_wall1_q <= wall1;
            r_hit2_q  <= hit2;
            r_wall2_q <= wall2;
        end
    end

    assign w_start_ev = start & ~r_start_q;
    assign w_hit1_ev  = hit1  & ~r_hit1_q;
    assign w_wall1_ev = wall1 & ~r_wall1_q;
    assign w_hit2_ev  = hit2  & ~r_hit2_q;
    assign w_wall2_ev = wall2 & ~r_wall2_q;

    // One extra bit of headroom so the sum can be compared before saturation
    assign w_inc1   = (w_hit1_ev ? c_HIT : 8'd0) + (w_wall1_ev ? c_WALL : 8'd0);
    assign w_inc2   = (w_hit2_ev ? c_HIT : 8'd0) + (w_wall2_ev ? c_WALL : 8'd0);
    assign w_sum1   = {1'b0, r_p1} + w_inc1;
    assign w_sum2   = {1'b0, r_p2} + w_inc2;
    assign w_reach1 = (w_sum1 >= {1'b0, c_WIN});
    assign w_reach2 = (w_sum2 >= {1'b0, c_WIN});
    assign w_sat1   = w_reach1 ? c_WIN : w_sum1[6:0];
    assign w_sat2   = w_reach2 ? c_WIN : w_sum2[6:0];

    // State, score and winner registers
    always_ff @(posedge clkdiv0 or posedge RST) begin
        if (RST) begin
            r_state  <= S_IDLE;
            r_p1     <= 7'd0;
            r_p2     <= 7'd0;
            r_winner <= 2'b00;
        end else begin
            r_state  <= w_state_nxt;
            r_p1     <= w_p1_nxt;
            r_p2     <= w_p2_nxt;
            r_winner <= w_winner_nxt;
        end
    end

    // Next-state logic; a start edge in PLAY falls through and is ignored
    always_comb begin
        w_state_nxt  = r_state;
        w_p1_nxt     = r_p1;
        w_p2_nxt     = r_p2;
        w_winner_nxt = r_winner;
        case (r_state)
            S_IDLE: begin
                if (w_start_ev) begin
                    w_state_nxt = S_PLAY;
                end
            end
            S_PLAY: begin
                w_p1_nxt = w_sat1;
                w_p2_nxt = w_sat2;
                if (w_reach1 || w_reach2) begin
                    w_state_nxt  = S_WIN;
                    // bit0 = player 1 reached, bit1 = player 2 reached; both = draw
                    w_winner_nxt = {w_reach2, w_reach1};
                end
            end
            S_WIN: begin
                if (w_start_ev) begin
                    w_state_nxt  = S_IDLE;
                    w_p1_nxt     = 7'd0;
                    w_p2_nxt     = 7'd0;
                    w_winner_nxt = 2'b00;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign p1_units  = 4'(r_p1 % 7'd10);
    assign p1_tens   = 4'(r_p1 / 7'd10);
    assign p2_units  = 4'(r_p2 % 7'd10);
    assign p2_tens   = 4'(r_p2 / 7'd10);
    assign state     = r_state;
    assign winner    = r_winner;
    assign game_over = (r_state == S_WIN);

endmodule

`default_nettype wire

// File: tb/tb_score_keeper.sv
`timescale 1ns/1ps
`default_nettype none

module tb_score_keeper;

    localparam int WS = 21;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       start = 1'b0;
    logic       h1    = 1'b0;
    logic       w1    = 1'b0;
    logic       h2    = 1'b0;
    logic       w2    = 1'b0;
    logic [3:0] p1u, p1t, p2u, p2t;
    logic [1:0] st, win;
    logic       go;

    score_keeper #(.WIN_SCORE(WS), .HIT_PTS(1), .WALL_PTS(2)) dut (
        .clkdiv0  (clk),
        .RST      (rst),
        .start    (start),
        .hit1     (h1),
        .wall1    (w1),
        .hit2     (h2),
        .wall2    (w2),
        .p1_units (p1u),
        .p1_tens  (p1t),
        .p2_units (p2u),
        .p2_tens  (p2t),
        .state    (st),
        .winner   (win),
        .game_over(go)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Behavioural reference: plain integer scores and game phase
    int m_s1, m_s2, m_st, m_win;
    bit m_ps, m_ph1, m_pw1, m_ph2, m_pw2;

    typedef struct {
        bit s, a, b, c, d;
        int p1, p2, st, win;
    } vec_t;
    vec_t tbl[256];
    int   n = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input int e1, input int e2,
                                 input int est, input int ewin);
        chk({tag, " p1_units"}, int'(p1u), e1 % 10);
        chk({tag, " p1_tens"},  int'(p1t), e1 / 10);
        chk({tag, " p2_units"}, int'(p2u), e2 % 10);
        chk({tag, " p2_tens"},  int'(p2t), e2 / 10);
        chk({tag, " state"},    int'(st),  est);
        chk({tag, " winner"},   int'(win), ewin);
        chk({tag, " game_over"}, int'(go), (est == 2) ? 1 : 0);
    endtask

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_st = 0; m_win = 0;
        m_ps = 0; m_ph1 = 0; m_pw1 = 0; m_ph2 = 0; m_pw2 = 0;
    endtask

    task automatic model_step();
        bit es, eh1, ew1, eh2, ew2;
        int n1, n2;
        es  = start && !m_ps;
        eh1 = h1 && !m_ph1;
        ew1 = w1 && !m_pw1;
        eh2 = h2 && !m_ph2;
        ew2 = w2 && !m_pw2;
        m_ps = start; m_ph1 = h1; m_pw1 = w1; m_ph2 = h2; m_pw2 = w2;
        if (m_st == 1) begin
            n1 = m_s1 + (eh1 ? 1 : 0) + (ew1 ? 2 : 0);
            n2 = m_s2 + (eh2 ? 1 : 0) + (ew2 ? 2 : 0);
            if (n1 > WS) n1 = WS;
            if (n2 > WS) n2 = WS;
            m_s1 = n1;
            m_s2 = n2;
            if (n1 >= WS || n2 >= WS) begin
                m_st  = 2;
                m_win = ((n1 >= WS) ? 1 : 0) + ((n2 >= WS) ? 2 : 0);
            end
        end else if (m_st == 2) begin
            if (es) begin
                m_st = 0; m_s1 = 0; m_s2 = 0; m_win = 0;
            end
        end else begin
            if (es) m_st = 1;
        end
    endtask

    task automatic drive(input bit s, input bit a, input bit b, input bit c, input bit d);
        @(negedge clk);
        start = s; h1 = a; w1 = b; h2 = c; w2 = d;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic add(input bit s, input bit a, input bit b, input bit c, input bit d,
                       input int p1, input int p2, input int est, input int ew);
        tbl[n] = '{s, a, b, c, d, p1, p2, est, ew};
        n++;
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_outputs("reset", 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;

        // ---- directed table ----
        add(1,0,0,0,0, 0,0,1,0);
        add(0,0,0,0,0, 0,0,1,0);
        for (int i = 1; i <= 3; i++) begin
            add(0,1,0,0,0, i,0,1,0);
            add(0,0,0,0,0, i,0,1,0);
        end
        for (int i = 0; i < 5; i++) add(0,1,0,0,0, 4,0,1,0);
        add(0,0,0,0,0, 4,0,1,0);
        add(0,0,0,1,1, 4,3,1,0);
        add(0,0,0,0,0, 4,3,1,0);
        add(0,0,0,0,1, 4,5,1,0);  add(0,0,0,0,0, 4,5,1,0);
        add(0,0,0,0,1, 4,7,1,0);  add(0,0,0,0,0, 4,7,1,0);
        add(0,0,0,1,0, 4,8,1,0);  add(0,0,0,0,0, 4,8,1,0);
        add(0,0,0,1,0, 4,9,1,0);  add(0,0,0,0,0, 4,9,1,0);
        add(0,0,0,0,1, 4,11,1,0); add(0,0,0,0,0, 4,11,1,0);
        add(1,0,0,0,0, 4,11,1,0); add(0,0,0,0,0, 4,11,1,0);
        for (int i = 1; i <= 8; i++) begin
            add(0,0,1,0,0, 4+2*i,11,1,0);
            add(0,0,0,0,0, 4+2*i,11,1,0);
        end
        add(0,0,1,0,0, 21,11,2,1);
        add(0,0,0,0,0, 21,11,2,1);
        add(0,0,0,1,0, 21,11,2,1);
        add(0,0,0,0,0, 21,11,2,1);
        add(1,0,0,0,0, 0,0,0,0);
        add(0,0,0,0,0, 0,0,0,0);
        add(1,0,0,0,0, 0,0,1,0);
        add(0,0,0,0,0, 0,0,1,0);
        for (int i = 1; i <= 10; i++) begin
            add(0,0,1,0,1, 2*i,2*i,1,0);
            add(0,0,0,0,0, 2*i,2*i,1,0);
        end
        add(0,1,0,1,0, 21,21,2,3);
        add(0,0,0,0,0, 21,21,2,3);
        add(1,0,0,0,0, 0,0,0,0);
        add(0,0,0,0,0, 0,0,0,0);
        add(1,0,0,0,0, 0,0,1,0);
        add(0,0,0,0,0, 0,0,1,0);
        for (int i = 1; i <= 10; i++) begin
            add(0,0,1,0,0, 2*i,0,1,0);
            add(0,0,0,0,0, 2*i,0,1,0);
        end
        add(1,0,1,0,0, 21,0,2,1);
        add(0,0,0,0,0, 21,0,2,1);
        add(1,0,0,0,0, 0,0,0,0);
        add(0,0,0,0,0, 0,0,0,0);

        for (int i = 0; i < n; i++) begin
            drive(tbl[i].s, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].d);
            tick();
            check_outputs($sformatf("vec%0d", i), tbl[i].p1, tbl[i].p2, tbl[i].st, tbl[i].win);
        end

        // ---- asynchronous reset mid-PLAY with p1 = 7 ----
        drive(1,0,0,0,0); tick();
        drive(0,0,0,0,0); tick();
        for (int i = 0; i < 3; i++) begin
            drive(0,1,0,0,0); tick();
            drive(0,0,0,0,0); tick();
        end
        for (int i = 0; i < 2; i++) begin
            drive(0,0,1,0,0); tick();
            drive(0,0,0,0,0); tick();
        end
        check_outputs("pre_async", 7, 0, 1, 0);
        #2 rst = 1'b1;
        #1;
        check_outputs("async_rst", 0, 0, 0, 0);

        // start already high at reset release counts as an edge
        @(negedge clk);
        start = 1'b1; h1 = 0; w1 = 0; h2 = 0; w2 = 0;
        rst = 1'b0;
        model_reset();
        tick();
        check_outputs("start_at_release", 0, 0, 1, 0);

        // ---- randomized run against the reference model ----
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
            tick();
            check_outputs($sformatf("rand%0d", i), m_s1, m_s2, m_st, m_win);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
